// File: rtl/meas_pkg.sv
// Shared types and default timing constants for the skew measurement strobe engine.
package meas_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        STROBE,
        CAPTURE,
        DONE
    } stb_state_t;

    localparam int STB_SETTLE_DEF = 8;
    localparam int STB_CAP_DEF    = 4;
    localparam int STB_NSAMP_DEF  = 5;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-stage synchroniser for bringing an asynchronous level into clk_i.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/stb_sampler.sv
// Strobe-and-sample engine: settle, strobe, capture the synchronised comparator,
// repeat NUM_SAMPLES times and report a majority vote with a one-cycle valid pulse.
module stb_sampler
    import meas_pkg::*;
#(
    parameter int SETTLE_CYCLES = STB_SETTLE_DEF,
    parameter int CAP_DELAY     = STB_CAP_DEF,
    parameter int NUM_SAMPLES   = STB_NSAMP_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       stb_req_i,
    output logic       stb_valid_o,
    output logic       cmp_result_o,
    output logic [7:0] ones_cnt_o,
    input  logic       cmp_i,
    output logic       stb_o,
    output logic       busy_o
);

    localparam int PHASE_MAX = (SETTLE_CYCLES > CAP_DELAY) ? SETTLE_CYCLES : CAP_DELAY;
    localparam int PW        = $clog2(PHASE_MAX + 1);

    localparam logic [PW-1:0] SETTLE_LAST = PW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0] CAP_LAST    = PW'(CAP_DELAY - 1);
    localparam logic [7:0]    NS_LAST     = 8'(NUM_SAMPLES - 1);
    localparam logic [7:0]    HALF        = 8'(NUM_SAMPLES / 2);

    if ((NUM_SAMPLES < 1) || (NUM_SAMPLES > 255) || ((NUM_SAMPLES % 2) == 0)) begin : g_badNumSamples
        $error("stb_sampler: NUM_SAMPLES must be odd and within 1..255");
    end
    if (CAP_DELAY < 3) begin : g_badCapDelay
        $error("stb_sampler: CAP_DELAY must be at least 3");
    end
    if (SETTLE_CYCLES < 1) begin : g_badSettle
        $error("stb_sampler: SETTLE_CYCLES must be at least 1");
    end

    stb_state_t    state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [7:0]    sampleCnt_q, sampleCnt_d;
    logic [7:0]    onesCnt_q, onesCnt_d;
    logic [7:0]    onesOut_q, onesOut_d;
    logic          cmpResult_q, cmpResult_d;
    logic          stb_q, valid_q, busy_q;
    logic          cmpSync;
    logic [7:0]    onesNext;

    sync_2ff u_cmpSync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (cmp_i),
        .q_o   (cmpSync)
    );

    // Results are published on the edge into DONE so they are already valid alongside stb_valid_o.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        sampleCnt_d = sampleCnt_q;
        onesCnt_d   = onesCnt_q;
        onesOut_d   = onesOut_q;
        cmpResult_d = cmpResult_q;
        onesNext    = onesCnt_q + {7'd0, cmpSync};

        case (state_q)
            IDLE: begin
                if (stb_req_i) begin
                    sampleCnt_d = 8'd0;
                    onesCnt_d   = 8'd0;
                    phase_d     = '0;
                    state_d     = SETTLE;
                end
            end
            SETTLE: begin
                if (phase_q == SETTLE_LAST) begin
                    phase_d = '0;
                    state_d = STROBE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            STROBE: begin
                phase_d = '0;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                if (phase_q == CAP_LAST) begin
                    phase_d     = '0;
                    onesCnt_d   = onesNext;
                    sampleCnt_d = sampleCnt_q + 8'd1;
                    if (sampleCnt_q == NS_LAST) begin
                        onesOut_d   = onesNext;
                        cmpResult_d = (onesNext > HALF);
                        state_d     = DONE;
                    end else begin
                        state_d = SETTLE;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobe, valid and busy are registered off the next state so they leave glitch-free flops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            sampleCnt_q <= 8'd0;
            onesCnt_q   <= 8'd0;
            onesOut_q   <= 8'd0;
            cmpResult_q <= 1'b0;
            stb_q       <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            sampleCnt_q <= sampleCnt_d;
            onesCnt_q   <= onesCnt_d;
            onesOut_q   <= onesOut_d;
            cmpResult_q <= cmpResult_d;
            stb_q       <= (state_d == STROBE);
            valid_q     <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign stb_o        = stb_q;
    assign stb_valid_o  = valid_q;
    assign busy_o       = busy_q;
    assign ones_cnt_o   = onesOut_q;
    assign cmp_result_o = cmpResult_q;

endmodule

// File: tb/tb_stb_sampler.sv
// Self-checking bench for stb_sampler: table-driven measurements scored through an expected-result queue,
// plus hand-written sequences for held requests, mid-measurement reset and a minimal parameter set.
module tb_stb_sampler;
    import meas_pkg::*;

    localparam int SET_A = 8;
    localparam int PER_A = 13;

    typedef struct packed {
        logic [7:0] ones;
        logic       res;
    } exp_t;

    typedef struct {
        logic [4:0] pat;
        logic [7:0] ones;
        logic       res;
        int         extraReq;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       reqA = 1'b0, cmpA = 1'b0;
    logic       validA, resA, stbA, busyA;
    logic [7:0] onesA;
    logic       reqB = 1'b0, cmpB = 1'b1;
    logic       validB, resB, stbB, busyB;
    logic [7:0] onesB;

    int   vecCount  = 0;
    int   missCount = 0;
    exp_t expQ[$];
    logic [7:0] modelOnes = 8'd0;
    logic       modelRes  = 1'b0;
    vec_t vecs[6];

    always #5 clk = ~clk;

    stb_sampler u_dutA (
        .clk_i        (clk),
        .rst_i        (rst),
        .stb_req_i    (reqA),
        .stb_valid_o  (validA),
        .cmp_result_o (resA),
        .ones_cnt_o   (onesA),
        .cmp_i        (cmpA),
        .stb_o        (stbA),
        .busy_o       (busyA)
    );

    stb_sampler #(.SETTLE_CYCLES(1), .CAP_DELAY(3), .NUM_SAMPLES(1)) u_dutB (
        .clk_i        (clk),
        .rst_i        (rst),
        .stb_req_i    (reqB),
        .stb_valid_o  (validB),
        .cmp_result_o (resB),
        .ones_cnt_o   (onesB),
        .cmp_i        (cmpB),
        .stb_o        (stbB),
        .busy_o       (busyB)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        vecCount++;
        if (act != exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic popAndCompare(input string tag);
        exp_t e;
        if (expQ.size() == 0) begin
            checkOutput({tag, "_unexpectedValid"}, 1, 0);
        end else begin
            e = expQ.pop_front();
            checkOutput({tag, "_ones"}, onesA, e.ones);
            checkOutput({tag, "_result"}, resA, e.res);
            modelOnes = e.ones;
            modelRes  = e.res;
        end
    endtask

    task automatic quietCheck(input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (stbA || validA) seen++;
        end
        checkOutput("quietPulses", seen, 0);
    endtask

    // One single-cycle request; cmp_i changes mid-SETTLE of each sample to the table bit.
    task automatic applyStimulus(input vec_t v);
        int  strobeIdx = 0;
        bit  gotValid  = 0;
        @(negedge clk);
        reqA = 1'b1;
        cmpA = ~v.pat[0];
        expQ.push_back('{ones: v.ones, res: v.res});
        for (int m = 1; m <= 90 && !gotValid; m++) begin
            @(negedge clk);
            reqA = (m == v.extraReq);
            if (m % PER_A == 5 && m / PER_A < 5) cmpA = v.pat[m / PER_A];
            if (m == 1) checkOutput("busyAfterReq", busyA, 1);
            if (stbA) begin
                checkOutput("strobeCycle", m, 1 + SET_A + PER_A * strobeIdx);
                checkOutput("holdOnes", onesA, modelOnes);
                checkOutput("holdResult", resA, modelRes);
                strobeIdx++;
            end
            if (validA) begin
                gotValid = 1;
                checkOutput("validCycle", m, 66);
                checkOutput("strobeCount", strobeIdx, 5);
                popAndCompare("vec");
            end
        end
        if (!gotValid) checkOutput("validTimeout", 0, 1);
        reqA = 1'b0;
    endtask

    initial begin
        int validCnt;
        bit gotB;

        vecs[0] = '{pat: 5'b11111, ones: 8'd5, res: 1'b1, extraReq: 0};
        vecs[1] = '{pat: 5'b00101, ones: 8'd2, res: 1'b0, extraReq: 0};
        vecs[2] = '{pat: 5'b01110, ones: 8'd3, res: 1'b1, extraReq: 0};
        vecs[3] = '{pat: 5'b00000, ones: 8'd0, res: 1'b0, extraReq: 11};
        vecs[4] = '{pat: 5'b11000, ones: 8'd2, res: 1'b0, extraReq: 0};
        vecs[5] = '{pat: 5'b10011, ones: 8'd3, res: 1'b1, extraReq: 40};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstStb", stbA, 0);
        checkOutput("rstValid", validA, 0);
        checkOutput("rstBusy", busyA, 0);
        checkOutput("rstResult", resA, 0);
        checkOutput("rstOnes", onesA, 0);
        checkOutput("rstBusyB", busyB, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            quietCheck(20);
        end

        // Level request held for 200 cycles: back-to-back measurements with no gap beyond IDLE.
        @(negedge clk);
        reqA = 1'b1;
        cmpA = 1'b0;
        repeat (3) expQ.push_back('{ones: 8'd0, res: 1'b0});
        validCnt = 0;
        for (int m = 1; m < 200; m++) begin
            @(negedge clk);
            if (validA) begin
                validCnt++;
                checkOutput("heldValidCycle", m, (validCnt == 1) ? 66 : 133);
                popAndCompare("held");
            end
        end
        checkOutput("heldValidCount", validCnt, 2);
        reqA = 1'b0;
        @(negedge clk);
        checkOutput("heldThirdValid", validA, 1);
        popAndCompare("held3");
        quietCheck(20);

        applyStimulus(vecs[0]);
        quietCheck(5);

        // Reset in the third SETTLE must abort cleanly with no residual pulses.
        @(negedge clk);
        reqA = 1'b1;
        cmpA = 1'b1;
        for (int m = 1; m <= 30; m++) begin
            @(negedge clk);
            reqA = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abortBusy", busyA, 0);
        checkOutput("abortOnes", onesA, 0);
        checkOutput("abortResult", resA, 0);
        checkOutput("abortStb", stbA, 0);
        checkOutput("abortValid", validA, 0);
        modelOnes = 8'd0;
        modelRes  = 1'b0;
        quietCheck(80);
        applyStimulus(vecs[2]);
        quietCheck(5);

        // Minimal configuration: one sample, one settle cycle, three capture cycles.
        @(negedge clk);
        reqB = 1'b1;
        gotB = 0;
        for (int m = 1; m <= 20 && !gotB; m++) begin
            @(negedge clk);
            reqB = 1'b0;
            if (stbB) checkOutput("minStrobeCycle", m, 2);
            if (validB) begin
                gotB = 1;
                checkOutput("minValidCycle", m, 6);
                checkOutput("minResult", resB, 1);
                checkOutput("minOnes", onesB, 1);
            end
        end
        if (!gotB) checkOutput("minValidTimeout", 0, 1);

        checkOutput("scoreboardDrained", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/stb_sampler.md
# stb_sampler

Strobe-and-sample engine that serves the skew measurement controller's strobe handshake. On each request it waits for the delay line to settle after a code change, fires a one-cycle strobe into the measured channel, and samples the synchronised comparator output. It repeats this NUM_SAMPLES times and returns a majority-voted comparator result with a valid pulse. It sits between the skew measurement controller (stb_req/stb_valid, delay code owner) and the analog front end (strobe out, comparator in).

## Interface
- SETTLE_CYCLES, 8: cycles waited before each strobe, so the delay line settles; must be ≥1
- CAP_DELAY, 4: cycles from the strobe cycle to the sample point; must be ≥3 to cover the 2-flop synchroniser plus 1
- NUM_SAMPLES, 5: strobes per request; odd, 1..255
- clk_i  in  1  system clock; one clock; reset is synchronous and active-high
- rst_i  in  1  synchronous active-high reset
- stb_req_i  in  1  request from controller; level, sampled only in IDLE
- stb_valid_o  out  1  one-cycle pulse: cmp_result_o/ones_cnt_o are valid
- cmp_result_o  out  1  majority vote of the comparator samples
- ones_cnt_o  out  8  number of samples that read 1 in the last request
- cmp_i  in  1  raw comparator output, asynchronous to clk_i
- stb_o  out  1  strobe pulse to the measured channel, one cycle wide
- busy_o  out  1  high in every state except IDLE

## Operation
- cmp_i passes through a 2-flop synchroniser to give cmp_s. It is never sampled raw.
- States:
  - IDLE: if stb_req_i=1, clear the ones and sample counters and go to SETTLE.
  - SETTLE: run for SETTLE_CYCLES cycles, then go to STROBE.
  - STROBE: stb_o=1 for exactly one cycle, then go to CAPTURE.
  - CAPTURE: run for CAP_DELAY cycles. On the last CAPTURE cycle, add cmp_s to ones_cnt and increment the sample counter. Go to DONE if this was sample NUM_SAMPLES, else go to SETTLE.
  - DONE: stb_valid_o=1 for one cycle, register the results, then go to IDLE.
- cmp_result_o = (ones_cnt > NUM_SAMPLES/2), using integer division.
- cmp_result_o and ones_cnt_o hold their values from DONE until the next DONE. They do not change during a measurement.
- The phase counter is wide enough for max(SETTLE_CYCLES, CAP_DELAY). The sample counter and ones counter are 8 bits and never wrap, because NUM_SAMPLES ≤ 255.
- stb_req_i is ignored while busy_o=1. A request held high through DONE starts a new measurement on the IDLE cycle after DONE; no request is lost or duplicated.
- Reset in any state forces IDLE on the next edge. It kills any stb_o or stb_valid_o pulse and clears the synchroniser, counters and outputs.
- There is no abort input. The controller drops stb_req_i, and the engine finishes the current measurement.

## Timing
- Reset values: stb_o=0, stb_valid_o=0, busy_o=0, cmp_result_o=0, ones_cnt_o=0, state=IDLE.
- Request seen in IDLE at edge k:
  - SETTLE occupies cycles k+1 .. k+SETTLE_CYCLES.
  - Each sample period P = SETTLE_CYCLES + 1 + CAP_DELAY.
  - The j-th strobe (j from 0) is at cycle k+1+j·P+SETTLE_CYCLES.
- stb_valid_o is high at cycle k+1+NUM_SAMPLES·P. With defaults (P=13), that is k+66.
- The next request can be accepted at cycle k+2+NUM_SAMPLES·P at the earliest.
- Each sample reflects the cmp_i level that was stable at least 2 edges before the sample edge.
- busy_o is registered from the state and changes on the same edge as the state.

## Structure
- Shared package meas_pkg:
  - stb_state_t enum with IDLE, SETTLE, STROBE, CAPTURE, DONE
  - default constants STB_SETTLE_DEF=8, STB_CAP_DEF=4, STB_NSAMP_DEF=5
- Sub-module sync_2ff: generic 1-bit, 2-stage synchroniser with synchronous reset, instantiated on cmp_i.
- Elaboration-time assertions for NUM_SAMPLES odd and in range, and CAP_DELAY ≥ 3.

## Test plan
- Reset, then one-cycle stb_req_i with cmp_i=1 held, defaults → stb_o pulses at k+9, 22, 35, 48, 61; stb_valid_o at k+66; ones_cnt_o=5, cmp_result_o=1.
- cmp_i toggled per strobe as 1,0,1,0,0, changed mid-SETTLE → ones_cnt_o=2, cmp_result_o=0.
- stb_req_i held high for 200 cycles → exactly two valid pulses; the second measurement's first SETTLE starts on the cycle after the first valid's IDLE acceptance.
- stb_req_i pulsed again during CAPTURE → ignored; only one stb_valid_o pulse; the outputs of the previous measurement are unchanged until DONE.
- rst_i asserted during the third SETTLE → next cycle IDLE, busy_o=0, ones_cnt_o=0, no stb_o or stb_valid_o pulse; a fresh request then completes normally.
- NUM_SAMPLES=1, SETTLE_CYCLES=1, CAP_DELAY=3, cmp_i=1 → stb_o at k+2, stb_valid_o at k+6, cmp_result_o=1.
